// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-stage controller. Chooses the next PC for the external PC register
// and decides when that register holds. Redirects are arbitrated by fixed
// priority: trap, then EX branch, then ID jump. A load-use hazard inserts a
// bubble. While instruction memory has not returned data, fetch is held and
// any redirect that arrives is parked in a one-entry pending slot.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   pc                      : current PC from the PC register
//   pc_next, pc_stall       : next PC and hold for the PC register
//   hazard_stall            : load-use hazard from the hazard unit
//   br_redirect, br_target  : EX branch taken / mispredict and its target
//   jal_redirect, jal_target: ID unconditional jump and its target
//   trap_req                : exception / trap request
//   imem_req, imem_ready    : fetch request for pc, fetch data returned
//   flush_if_id, flush_id_ex: pipeline squash controls
//   epc                     : PC captured when a trap is taken
//   misaligned              : one-cycle pulse, applied target had bits[1:0]!=0
//   state                   : FSM state for debug
module pc_sequencer #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h0000_0000_0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_stall,
  input  logic            hazard_stall,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_redirect,
  input  logic [XLEN-1:0] jal_target,
  input  logic            trap_req,
  output logic            imem_req,
  input  logic            imem_ready,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2,
    TRAP     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            pendValid_q, pendValid_d;
  logic [XLEN-1:0] pendTarget_q, pendTarget_d;
  logic            pendMis_q, pendMis_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] brAligned;
  logic [XLEN-1:0] jalAligned;

  // Redirect chosen this cycle (RUN) or the effective pending entry (WAIT_MEM)
  logic            redirValid;
  logic [XLEN-1:0] redirTarget;
  logic            redirMis;

  assign pcPlus4    = pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign brAligned  = {br_target[XLEN-1:2], 2'b00};
  assign jalAligned = {jal_target[XLEN-1:2], 2'b00};

  // Next-state and output decode. Outputs are combinational from state and
  // inputs; reset forces the PC register to hold and silences fetch.
  always_comb begin
    pc_next      = pcPlus4;
    pc_stall     = 1'b0;
    imem_req     = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    state_d      = state_q;
    pendValid_d  = pendValid_q;
    pendTarget_d = pendTarget_q;
    pendMis_d    = pendMis_q;
    epc_d        = epc_q;
    mis_d        = 1'b0;
    redirValid   = 1'b0;
    redirTarget  = pcPlus4;
    redirMis     = 1'b0;

    case (state_q)
      BOOT: begin
        pc_next = RESET_PC;
        state_d = RUN;
      end

      RUN: begin
        imem_req = 1'b1;
        if (trap_req) begin
          // Trap wins over everything; any branch this cycle is discarded.
          pc_next     = pc;
          pc_stall    = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          epc_d       = pc;
          state_d     = TRAP;
        end else begin
          if (br_redirect) begin
            redirValid  = 1'b1;
            redirTarget = brAligned;
            redirMis    = |br_target[1:0];
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (jal_redirect && !hazard_stall) begin
            // A jump under a hazard is dropped; ID presents it again.
            redirValid  = 1'b1;
            redirTarget = jalAligned;
            redirMis    = |jal_target[1:0];
            flush_if_id = 1'b1;
          end else if (hazard_stall) begin
            pc_stall    = 1'b1;
            flush_id_ex = 1'b1;
          end
          pc_next = redirTarget;
          if (!imem_ready) begin
            // Fetch blocked: park the redirect until memory answers.
            pc_stall     = 1'b1;
            pendValid_d  = redirValid;
            pendTarget_d = redirTarget;
            pendMis_d    = redirMis;
            state_d      = WAIT_MEM;
          end else begin
            mis_d = redirMis;
          end
        end
      end

      WAIT_MEM: begin
        imem_req = 1'b1;
        pc_stall = 1'b1;
        pc_next  = pc;
        if (trap_req) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          epc_d       = pc;
          pendValid_d = 1'b0;
          state_d     = TRAP;
        end else begin
          redirValid  = pendValid_q;
          redirTarget = pendTarget_q;
          redirMis    = pendMis_q;
          // A branch replaces whatever is parked; a jump only fills a hole.
          if (br_redirect) begin
            redirValid  = 1'b1;
            redirTarget = brAligned;
            redirMis    = |br_target[1:0];
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (jal_redirect && !pendValid_q) begin
            redirValid  = 1'b1;
            redirTarget = jalAligned;
            redirMis    = |jal_target[1:0];
            flush_if_id = 1'b1;
          end
          if (imem_ready) begin
            pc_stall    = 1'b0;
            pendValid_d = 1'b0;
            state_d     = RUN;
            if (redirValid) begin
              pc_next = redirTarget;
              mis_d   = redirMis;
            end else begin
              pc_next = pcPlus4;
            end
          end else begin
            pendValid_d  = redirValid;
            pendTarget_d = redirTarget;
            pendMis_d    = redirMis;
          end
        end
      end

      TRAP: begin
        pc_next     = TRAP_VECTOR;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = RUN;
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    if (rst) begin
      pc_next     = RESET_PC;
      pc_stall    = 1'b1;
      imem_req    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  // State, pending slot, trap PC and misaligned pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pendValid_q  <= 1'b0;
      pendTarget_q <= '0;
      pendMis_q    <= 1'b0;
      epc_q        <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pendValid_q  <= pendValid_d;
      pendTarget_q <= pendTarget_d;
      pendMis_q    <= pendMis_d;
      epc_q        <= epc_d;
      mis_q        <= mis_d;
    end
  end

  assign epc        = epc_q;
  assign misaligned = mis_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. The bench owns the PC register that the
// sequencer steers (reset value -4, holds on pc_stall), drives redirect and
// memory inputs, and compares outputs with hand-computed values.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic        pc_stall;
  logic        hazard_stall;
  logic        br_redirect;
  logic [63:0] br_target;
  logic        jal_redirect;
  logic [63:0] jal_target;
  logic        trap_req;
  logic        imem_req;
  logic        imem_ready;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [63:0] epc;
  logic        misaligned;
  logic [1:0]  state;

  int errorCount;
  int checkCount;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_next      (pc_next),
    .pc_stall     (pc_stall),
    .hazard_stall (hazard_stall),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .jal_redirect (jal_redirect),
    .jal_target   (jal_target),
    .trap_req     (trap_req),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .epc          (epc),
    .misaligned   (misaligned),
    .state        (state)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register steered by the sequencer
  always @(posedge clk) begin
    if (rst) pc <= 64'hFFFF_FFFF_FFFF_FFFC;
    else if (!pc_stall) pc <= pc_next;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic hz, input logic br, input logic [63:0] brT,
                               input logic jal, input logic [63:0] jalT,
                               input logic trap, input logic ready);
    hazard_stall = hz;
    br_redirect  = br;
    br_target    = brT;
    jal_redirect = jal;
    jal_target   = jalT;
    trap_req     = trap;
    imem_ready   = ready;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);

    // Reset held for two cycles
    nextCycle;
    #1;
    checkOutput("rst_stall", 64'(pc_stall), 64'd1);
    checkOutput("rst_imem", 64'(imem_req), 64'd0);
    checkOutput("rst_pcnext", pc_next, 64'h0);
    checkOutput("rst_flush", 64'({flush_if_id, flush_id_ex}), 64'd0);
    checkOutput("rst_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    nextCycle;
    rst = 1'b0;
    #1;
    // BOOT
    checkOutput("boot_state", 64'(state), 64'd0);
    checkOutput("boot_pcnext", pc_next, 64'h0);
    checkOutput("boot_stall", 64'(pc_stall), 64'd0);
    checkOutput("boot_imem", 64'(imem_req), 64'd0);
    checkOutput("boot_epc", epc, 64'h0);

    // RUN sequence 0, 4, 8
    nextCycle; #1;
    checkOutput("run_pc0", pc, 64'h0);
    checkOutput("run_state", 64'(state), 64'd1);
    checkOutput("run_pcnext4", pc_next, 64'h4);
    checkOutput("run_imem", 64'(imem_req), 64'd1);
    nextCycle; #1;
    checkOutput("run_pc4", pc, 64'h4);
    nextCycle;
    checkOutput("run_pc8", pc, 64'h8);

    // Load-use stall at pc=8
    applyStimulus(1, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("hz_stall", 64'(pc_stall), 64'd1);
    checkOutput("hz_flush_id_ex", 64'(flush_id_ex), 64'd1);
    checkOutput("hz_flush_if_id", 64'(flush_if_id), 64'd0);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("hz_pc_held", pc, 64'h8);
    checkOutput("hz_pcnext", pc_next, 64'hC);
    nextCycle; #1;
    checkOutput("hz_pcC", pc, 64'hC);
    nextCycle;
    checkOutput("pc10", pc, 64'h10);

    // Branch beats jump and hazard
    applyStimulus(1, 1, 64'h40, 1, 64'h80, 0, 1);
    #1;
    checkOutput("br_pcnext", pc_next, 64'h40);
    checkOutput("br_flushes", 64'({flush_if_id, flush_id_ex}), 64'b11);
    checkOutput("br_stall", 64'(pc_stall), 64'd0);
    nextCycle;
    checkOutput("br_pc40", pc, 64'h40);
    checkOutput("br_mis", 64'(misaligned), 64'd0);

    // Jump to 0x20 (no hazard)
    applyStimulus(0, 0, 64'h0, 1, 64'h20, 0, 1);
    #1;
    checkOutput("jal_pcnext", pc_next, 64'h20);
    checkOutput("jal_flushes", 64'({flush_if_id, flush_id_ex}), 64'b10);
    nextCycle;
    checkOutput("jal_pc20", pc, 64'h20);

    // Redirects during memory wait
    applyStimulus(0, 0, 64'h0, 1, 64'h60, 0, 0);
    #1;
    checkOutput("w1_stall", 64'(pc_stall), 64'd1);
    checkOutput("w1_flush_if_id", 64'(flush_if_id), 64'd1);
    nextCycle;
    applyStimulus(0, 1, 64'h90, 0, 64'h0, 0, 0);
    #1;
    checkOutput("w2_state", 64'(state), 64'd2);
    checkOutput("w2_stall", 64'(pc_stall), 64'd1);
    checkOutput("w2_imem", 64'(imem_req), 64'd1);
    checkOutput("w2_pc", pc, 64'h20);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 0);
    #1;
    checkOutput("w3_pc", pc, 64'h20);
    checkOutput("w3_stall", 64'(pc_stall), 64'd1);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("w4_pcnext", pc_next, 64'h90);
    checkOutput("w4_stall", 64'(pc_stall), 64'd0);
    nextCycle;
    checkOutput("w_pc90", pc, 64'h90);
    checkOutput("w_state", 64'(state), 64'd1);

    // Branch to 0x34
    applyStimulus(0, 1, 64'h34, 0, 64'h0, 0, 1);
    nextCycle;
    checkOutput("pc34", pc, 64'h34);

    // Trap together with a branch
    applyStimulus(0, 1, 64'h200, 0, 64'h0, 1, 1);
    #1;
    checkOutput("trap_flushes1", 64'({flush_if_id, flush_id_ex}), 64'b11);
    checkOutput("trap_stall", 64'(pc_stall), 64'd1);
    nextCycle;
    applyStimulus(0, 1, 64'h200, 1, 64'h300, 0, 1);
    #1;
    checkOutput("trap_epc", epc, 64'h34);
    checkOutput("trap_state", 64'(state), 64'd3);
    checkOutput("trap_pcnext", pc_next, 64'h100);
    checkOutput("trap_flushes2", 64'({flush_if_id, flush_id_ex}), 64'b11);
    checkOutput("trap_imem", 64'(imem_req), 64'd0);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("trap_pc100", pc, 64'h100);
    checkOutput("trap_run", 64'(state), 64'd1);

    // Misaligned branch target
    applyStimulus(0, 1, 64'h43, 0, 64'h0, 0, 1);
    #1;
    checkOutput("mis_pcnext", pc_next, 64'h40);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("mis_pulse", 64'(misaligned), 64'd1);
    checkOutput("mis_pc40", pc, 64'h40);
    nextCycle; #1;
    checkOutput("mis_clear", 64'(misaligned), 64'd0);

    // Wrap from the top of the address space
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 1);
    nextCycle;
    applyStimulus(0, 0, 64'h0, 0, 64'h0, 0, 1);
    #1;
    checkOutput("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_pcnext", pc_next, 64'h0);
    nextCycle; #1;
    checkOutput("wrap_pc0", pc, 64'h0);

    // Reset mid-operation clears state and epc
    rst = 1'b1;
    nextCycle; #1;
    checkOutput("rst2_state", 64'(state), 64'd0);
    checkOutput("rst2_epc", epc, 64'h0);
    checkOutput("rst2_stall", 64'(pc_stall), 64'd1);
    rst = 1'b0;
    nextCycle; #1;
    checkOutput("rst2_run", 64'(state), 64'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller that generates PC_NEXT and the stall for the 64-bit PC register, which resets to -4.
- Arbitrates redirect sources (trap, EX branch/mispredict, ID jump) by fixed priority and applies load-use hazard stalls.
- Handles instruction-memory handshake wait states, holding redirects that arrive while fetch is blocked.
- Drives pipeline flushes.

Parameters:
- XLEN, 64, datapath/PC width
- RESET_PC, 64'd0, first fetch address after reset
- TRAP_VECTOR, 64'h0000_0000_0000_0100, trap handler entry address

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- pc  input  XLEN  current PC from PC register
- pc_next  output  XLEN  next PC to PC register
- pc_stall  output  1  hold PC register
- hazard_stall  input  1  load-use hazard from hazard unit
- br_redirect  input  1  EX branch taken/mispredict
- br_target  input  XLEN  EX redirect target
- jal_redirect  input  1  ID unconditional jump
- jal_target  input  XLEN  ID jump target
- trap_req  input  1  exception/trap request
- imem_req  output  1  fetch request for address pc
- imem_ready  input  1  fetch data returned this cycle
- flush_if_id  output  1  squash IF/ID register
- flush_id_ex  output  1  squash ID/EX register
- epc  output  XLEN  PC captured at trap
- misaligned  output  1  1-cycle pulse: applied target had bits[1:0]!=0
- state  output  2  FSM state, for debug

Behaviour:
- FSM: BOOT=0, RUN=1, WAIT_MEM=2, TRAP=3. Registered state; all outputs are combinational from state and inputs.
- Reset:
  - state=BOOT; pending_valid=0; epc=0; misaligned=0.
  - While rst=1: pc_stall=1, imem_req=0, flush_*=0, pc_next=RESET_PC.
- BOOT (one cycle after rst falls):
  - pc_next=RESET_PC, pc_stall=0, imem_req=0.
  - Next state is RUN.
- RUN:
  - imem_req=1; default pc_next=pc+4 (mod 2^XLEN, wrap silently).
  - Priority 1, trap_req: flush_if_id=flush_id_ex=1, pc_stall=1, epc<=pc, next state TRAP.
  - Priority 2, br_redirect: pc_next={br_target[XLEN-1:2],2'b00}, flush_if_id=flush_id_ex=1. Overrides hazard_stall.
  - Priority 3, jal_redirect with hazard_stall=0: pc_next={jal_target[XLEN-1:2],2'b00}, flush_if_id=1. With hazard_stall=1, the jump is ignored; ID re-presents it next cycle.
  - hazard_stall alone: pc_stall=1, flush_id_ex=1 (bubble).
  - imem_ready=0: pc_stall=1; any redirect from priorities 2/3 is latched into pending (target, type); next state WAIT_MEM. Flushes still assert in that cycle.
  - misaligned pulses when the applied target's [1:0]!=0.
- WAIT_MEM:
  - imem_req=1, pc_stall=1.
  - New br_redirect overwrites pending of any type; jal_redirect only fills an empty pending.
  - On imem_ready=1: if pending, pc_next=pending target, pending_valid<=0; else pc_next=pc+4. pc_stall=0, next state RUN.
  - trap_req in WAIT_MEM behaves as in RUN: epc<=pc, pending cleared, next state TRAP.
- TRAP (exactly 1 cycle):
  - pc_next=TRAP_VECTOR, pc_stall=0, imem_req=0.
  - flush_if_id=flush_id_ex=1; all redirect inputs ignored.
  - Next state RUN.
- rst mid-operation: next edge returns state to BOOT and drops pending. epc clears.
- Simultaneous trap_req + br_redirect: trap wins and the branch is discarded.

Test Plan:
- Reset then run:
  - Stimulus: rst high 2 cycles, release; imem_ready=1.
  - Required: BOOT pc_next=0. PC sequence 0,4,8,0xC. imem_req=0 during rst/BOOT.
- Load-use stall:
  - Stimulus: at pc=0x8 assert hazard_stall 1 cycle.
  - Required: pc_stall=1, flush_id_ex=1, flush_if_id=0. Next PC 0xC.
- Branch beats jump and hazard:
  - Stimulus: at pc=0x10 assert br_redirect (target 0x40), jal_redirect (0x80), and hazard_stall together.
  - Required: pc_next=0x40, both flushes=1, no stall.
- Redirect during memory wait:
  - Stimulus: at pc=0x20 set imem_ready=0 for 3 cycles; jal_redirect (0x60) in cycle 1, br_redirect (0x90) in cycle 2.
  - Required: PC holds 0x20. On ready, pc_next=0x90.
- Trap:
  - Stimulus: trap_req at pc=0x34 together with br_redirect (0x200).
  - Required: epc=0x34, flushes for 2 cycles, then pc_next=0x100. The branch is dropped.
- Misaligned and wrap:
  - Stimulus: br_target=0x43; separately pc=0xFFFF_FFFF_FFFF_FFFC in RUN.
  - Required: pc_next=0x40 with a misaligned pulse; pc_next wraps to 0.
